maq_bcd_mod: RTL and testbench
==============================

# maq_bcd_mod

Parametrised two-digit BCD modulo counter, the generic building block for the clock's seconds, minutes and hours stages. Advances on a one-cycle enable tick, wraps at a configurable modulus, and emits a registered single-cycle carry pulse that drives the next stage's enable. Supports synchronous preset (time setting) with range checking and, optionally, down-counting with borrow.

## Interface
- `MODULO`, 60: count range 0..MODULO-1; legal 2..100.
- `MSD_W`, 3: width of the tens digit; must satisfy 2^MSD_W > (MODULO-1)/10.
- `RESET_VAL`, 0: binary value loaded on reset; must be < MODULO.

- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-low; the block is reset on a rising `clock` edge with `reset`=0.
- `enable`  in  1: count tick, one cycle wide; typically the 1 Hz strobe or the upstream `carry`.
- `load`  in  1: preset strobe.
- `load_lsd`  in  4: preset units digit.
- `load_msd`  in  MSD_W: preset tens digit.
- `dir`  in  1: 1 = down, 0 = up; present only with `MAQ_BCD_DOWN_EN`.
- `bcd_lsd`  out  4: units digit.
- `bcd_msd`  out  MSD_W: tens digit.
- `carry`  out  1: one-cycle pulse on up-wrap.
- `borrow`  out  1: one-cycle pulse on down-wrap; present only with `MAQ_BCD_DOWN_EN`.
- `load_err`  out  1: one-cycle pulse when a preset is rejected.

## Operation
- State: the two BCD digits plus the registered pulse outputs. Value V = 10*msd + lsd; invariant lsd ≤ 9 and V < MODULO.
- Priority per edge: reset > load > enable > hold.
- Reset (`reset`=0): digits = RESET_VAL in BCD; `carry`, `borrow`, `load_err` = 0.
- Load: accepted if `load_lsd` ≤ 9 and 10*`load_msd`+`load_lsd` < MODULO. Then digits take the preset value and `load_err`=0. Otherwise the digits are unchanged and `load_err`=1. A coincident `enable` is dropped: no count and no carry/borrow.
- Up count (`enable`=1, `dir`=0 or macro absent):
  - V = MODULO-1 → 00, `carry`=1. This check precedes the lsd = 9 check.
  - else lsd = 9 → lsd 0, msd+1.
  - else lsd+1.
- Down count (`enable`=1, `dir`=1):
  - V = 0 → MODULO-1 in BCD, `borrow`=1.
  - else lsd = 0 → lsd 9, msd-1.
  - else lsd-1.
- `carry`, `borrow` and `load_err` are 0 in every cycle that does not produce their event, including cycles with `enable`=0. They never stick high.
- All arithmetic is done per digit in BCD. No binary-to-BCD conversion on the count path. msd arithmetic is MSD_W bits wide and cannot overflow under the invariant.

## Timing
- All outputs are registered. A tick or load sampled at edge N is visible after edge N; latency is 1 cycle.
- `carry`/`borrow` are high during exactly the cycle in which the wrapped value (00 or MODULO-1) is first shown, so a downstream stage using `carry` as `enable` updates one cycle later.
- Back-to-back `enable` every cycle is legal; each cycle advances once.
- Reset mid-count takes effect at the next edge. Any pending pulse is cleared in that same cycle.
- Load during a wrap cycle: load wins and no pulse is generated.

## Configuration
- `MAQ_BCD_DOWN_EN` defined: the `dir` and `borrow` ports exist and down-counting works as specified.
- `MAQ_BCD_DOWN_EN` undefined: the `dir` and `borrow` ports are absent and the block counts up only. Area is reduced; all other behaviour is identical.

## Test plan
- MODULO=60, reset=0 then 1, 60 enable ticks → counts 00..59 then 00; `carry` high exactly once, in the cycle showing 00; `carry` low while `enable`=0.
- MODULO=24, load 2/3, one tick → shows 00 with `carry`=1; load 2/4 → `load_err`=1 for one cycle, value stays 00.
- MODULO=60, load msd=4 lsd=5 with `enable`=1 in the same cycle → shows 45, no carry; next tick → 46. Load lsd=10 → `load_err`=1, value unchanged.
- `reset`=0 asserted while showing 59 with `enable`=1 → next cycle shows RESET_VAL (00) with `carry`=0.
- `MAQ_BCD_DOWN_EN`, MODULO=60, `dir`=1, from 10 tick → 09; from 00 tick → 59 with `borrow`=1 for one cycle, `carry`=0.
- Chain of three instances (60, 60, 24), each `enable` fed by the previous stage's `carry`, starting from 23:59:59, one tick → 00:00:00, with each stage rolling over on successive cycles.

Source files
------------

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter with preset, range-checked load and registered carry.
// Optional down-counting with borrow is compiled in when MAQ_BCD_DOWN_EN is defined.
module maq_bcd_mod #(
    parameter int MODULO    = 60,
    parameter int MSD_W     = 3,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [3:0]       load_lsd,
    input  logic [MSD_W-1:0] load_msd,
`ifdef MAQ_BCD_DOWN_EN
    input  logic             dir,
`endif
    output logic [3:0]       bcd_lsd,
    output logic [MSD_W-1:0] bcd_msd,
    output logic             carry,
`ifdef MAQ_BCD_DOWN_EN
    output logic             borrow,
`endif
    output logic             load_err
);

    localparam logic [3:0]       MAX_LSD = 4'((MODULO - 1) % 10);
    localparam logic [MSD_W-1:0] MAX_MSD = MSD_W'((MODULO - 1) / 10);
    localparam logic [3:0]       RST_LSD = 4'(RESET_VAL % 10);
    localparam logic [MSD_W-1:0] RST_MSD = MSD_W'(RESET_VAL / 10);
    localparam logic [MSD_W-1:0] MSD_ONE = MSD_W'(1);
    localparam logic [15:0]      MOD_16  = 16'(MODULO);

    logic [3:0]       lsd_q, lsd_d;
    logic [MSD_W-1:0] msd_q, msd_d;
    logic             carry_q, carry_d;
    logic             load_err_q, load_err_d;
`ifdef MAQ_BCD_DOWN_EN
    logic             borrow_q, borrow_d;
`endif

    logic [15:0] load_val;
    logic        load_ok;
    logic        at_max;
    logic        at_zero;

    // The preset range check is the only place a binary value is formed.
    assign load_val = 16'(load_msd) * 16'd10 + 16'(load_lsd);
    assign load_ok  = (load_lsd <= 4'd9) && (load_val < MOD_16);
    assign at_max   = (lsd_q == MAX_LSD) && (msd_q == MAX_MSD);
    assign at_zero  = (lsd_q == 4'd0) && (msd_q == '0);

    always_comb begin
        lsd_d      = lsd_q;
        msd_d      = msd_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
`ifdef MAQ_BCD_DOWN_EN
        borrow_d   = 1'b0;
`endif
        if (load) begin
            // A coincident enable is deliberately dropped here.
            if (load_ok) begin
                lsd_d = load_lsd;
                msd_d = load_msd;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable) begin
`ifdef MAQ_BCD_DOWN_EN
            if (dir) begin
                if (at_zero) begin
                    lsd_d    = MAX_LSD;
                    msd_d    = MAX_MSD;
                    borrow_d = 1'b1;
                end else if (lsd_q == 4'd0) begin
                    lsd_d = 4'd9;
                    msd_d = msd_q - MSD_ONE;
                end else begin
                    lsd_d = lsd_q - 4'd1;
                end
            end else
`endif
            begin
                // Wrap test must come before the units-digit rollover test.
                if (at_max) begin
                    lsd_d   = 4'd0;
                    msd_d   = '0;
                    carry_d = 1'b1;
                end else if (lsd_q == 4'd9) begin
                    lsd_d = 4'd0;
                    msd_d = msd_q + MSD_ONE;
                end else begin
                    lsd_d = lsd_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lsd_q      <= RST_LSD;
            msd_q      <= RST_MSD;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
`ifdef MAQ_BCD_DOWN_EN
            borrow_q   <= 1'b0;
`endif
        end else begin
            lsd_q      <= lsd_d;
            msd_q      <= msd_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
`ifdef MAQ_BCD_DOWN_EN
            borrow_q   <= borrow_d;
`endif
        end
    end

    assign bcd_lsd  = lsd_q;
    assign bcd_msd  = msd_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;
`ifdef MAQ_BCD_DOWN_EN
    assign borrow   = borrow_q;
`endif

endmodule

// File: tb/tb_maq_bcd_mod.sv
// Directed bench for maq_bcd_mod: mod-60 and mod-24 counters plus a 60/60/24 clock chain.
// Down-count checks are included when MAQ_BCD_DOWN_EN is defined.
module tb_maq_bcd_mod;

    logic clock = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    // Mod-60 counter under test
    logic       en60, ld60;
    logic [3:0] ldl60;
    logic [2:0] ldm60;
    logic [3:0] l60;
    logic [2:0] m60;
    logic       c60, e60;
`ifdef MAQ_BCD_DOWN_EN
    logic       dir60, b60;
`endif

    // Mod-24 counter, non-zero reset value
    logic       en24, ld24;
    logic [3:0] ldl24;
    logic [1:0] ldm24;
    logic [3:0] l24;
    logic [1:0] m24;
    logic       c24, e24;
`ifdef MAQ_BCD_DOWN_EN
    logic       b24;
`endif

    // Seconds / minutes / hours chain
    logic       en_c, ld_c;
    logic [3:0] s_l, mi_l, h_l;
    logic [2:0] s_m, mi_m;
    logic [1:0] h_m;
    logic       s_c, mi_c, h_c;
    logic       s_e, mi_e, h_e;
`ifdef MAQ_BCD_DOWN_EN
    logic       s_b, mi_b, h_b;
`endif

    maq_bcd_mod #(.MODULO(60), .MSD_W(3), .RESET_VAL(0)) u60 (
        .clock(clock), .reset(rst_n), .enable(en60), .load(ld60),
        .load_lsd(ldl60), .load_msd(ldm60),
`ifdef MAQ_BCD_DOWN_EN
        .dir(dir60), .borrow(b60),
`endif
        .bcd_lsd(l60), .bcd_msd(m60), .carry(c60), .load_err(e60)
    );

    maq_bcd_mod #(.MODULO(24), .MSD_W(2), .RESET_VAL(7)) u24 (
        .clock(clock), .reset(rst_n), .enable(en24), .load(ld24),
        .load_lsd(ldl24), .load_msd(ldm24),
`ifdef MAQ_BCD_DOWN_EN
        .dir(1'b0), .borrow(b24),
`endif
        .bcd_lsd(l24), .bcd_msd(m24), .carry(c24), .load_err(e24)
    );

    maq_bcd_mod #(.MODULO(60), .MSD_W(3), .RESET_VAL(0)) u_sec (
        .clock(clock), .reset(rst_n), .enable(en_c), .load(ld_c),
        .load_lsd(4'd9), .load_msd(3'd5),
`ifdef MAQ_BCD_DOWN_EN
        .dir(1'b0), .borrow(s_b),
`endif
        .bcd_lsd(s_l), .bcd_msd(s_m), .carry(s_c), .load_err(s_e)
    );

    maq_bcd_mod #(.MODULO(60), .MSD_W(3), .RESET_VAL(0)) u_min (
        .clock(clock), .reset(rst_n), .enable(s_c), .load(ld_c),
        .load_lsd(4'd9), .load_msd(3'd5),
`ifdef MAQ_BCD_DOWN_EN
        .dir(1'b0), .borrow(mi_b),
`endif
        .bcd_lsd(mi_l), .bcd_msd(mi_m), .carry(mi_c), .load_err(mi_e)
    );

    maq_bcd_mod #(.MODULO(24), .MSD_W(2), .RESET_VAL(0)) u_hr (
        .clock(clock), .reset(rst_n), .enable(mi_c), .load(ld_c),
        .load_lsd(4'd3), .load_msd(2'd2),
`ifdef MAQ_BCD_DOWN_EN
        .dir(1'b0), .borrow(h_b),
`endif
        .bcd_lsd(h_l), .bcd_msd(h_m), .carry(h_c), .load_err(h_e)
    );

    // Advance one edge and settle; inputs are changed right after this returns.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({1'b0, m60, l60} !== 8'h00) begin
            errors++; $display("FAIL reset_u60 got=%h exp=00", {1'b0, m60, l60});
        end
        checks++;
        if ({c60, e60} !== 2'b00) begin
            errors++; $display("FAIL reset_u60_pulses got=%b exp=00", {c60, e60});
        end
        checks++;
        if ({2'b0, m24, l24} !== 8'h07) begin
            errors++; $display("FAIL reset_u24 got=%h exp=07", {2'b0, m24, l24});
        end
        checks++;
        if ({c24, e24} !== 2'b00) begin
            errors++; $display("FAIL reset_u24_pulses got=%b exp=00", {c24, e24});
        end
        rst_n = 1'b1;
    endtask

    // 60 back-to-back ticks with an idle cycle after every 7th
    task automatic test_count_up();
        int exp_v;
        int carries;
        carries = 0;
        for (int i = 0; i < 60; i++) begin
            en60 = 1'b1;
            step();
            exp_v = (i + 1) % 60;
            if (c60) carries++;
            checks++;
            if ({1'b0, m60, l60} !== 8'(((exp_v / 10) << 4) | (exp_v % 10))) begin
                errors++; $display("FAIL up_value i=%0d got=%h exp=%0d", i, {1'b0, m60, l60}, exp_v);
            end
            checks++;
            if (c60 !== (exp_v == 0)) begin
                errors++; $display("FAIL up_carry i=%0d got=%b exp=%b", i, c60, exp_v == 0);
            end
            if (i % 7 == 6 || i == 59) begin
                en60 = 1'b0;
                step();
                checks++;
                if ({c60, 1'b0, m60, l60} !== {1'b0, 8'(((exp_v / 10) << 4) | (exp_v % 10))}) begin
                    errors++; $display("FAIL up_hold i=%0d got=%b/%h exp=0/%0d", i, c60, {1'b0, m60, l60}, exp_v);
                end
            end
        end
        en60 = 1'b0;
        checks++;
        if (carries !== 1) begin
            errors++; $display("FAIL up_carry_count got=%0d exp=1", carries);
        end
    endtask

    task automatic test_mod24();
        ld24 = 1'b1; ldm24 = 2'd2; ldl24 = 4'd3;
        step();
        ld24 = 1'b0;
        checks++;
        if ({e24, 2'b0, m24, l24} !== {1'b0, 8'h23}) begin
            errors++; $display("FAIL m24_load got=%b/%h exp=0/23", e24, {2'b0, m24, l24});
        end
        en24 = 1'b1;
        step();
        en24 = 1'b0;
        checks++;
        if ({c24, 2'b0, m24, l24} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL m24_wrap got=%b/%h exp=1/00", c24, {2'b0, m24, l24});
        end
        step();
        checks++;
        if (c24 !== 1'b0) begin
            errors++; $display("FAIL m24_carry_clear got=%b exp=0", c24);
        end
        ld24 = 1'b1; ldm24 = 2'd2; ldl24 = 4'd4;
        step();
        ld24 = 1'b0;
        checks++;
        if ({e24, 2'b0, m24, l24} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL m24_reject got=%b/%h exp=1/00", e24, {2'b0, m24, l24});
        end
        step();
        checks++;
        if (e24 !== 1'b0) begin
            errors++; $display("FAIL m24_err_clear got=%b exp=0", e24);
        end
    endtask

    task automatic test_load_priority();
        ld60 = 1'b1; en60 = 1'b1; ldm60 = 3'd4; ldl60 = 4'd5;
        step();
        ld60 = 1'b0;
        checks++;
        if ({c60, e60, 1'b0, m60, l60} !== {2'b00, 8'h45}) begin
            errors++; $display("FAIL load_en got=%b%b/%h exp=00/45", c60, e60, {1'b0, m60, l60});
        end
        step();
        en60 = 1'b0;
        checks++;
        if ({1'b0, m60, l60} !== 8'h46) begin
            errors++; $display("FAIL load_next got=%h exp=46", {1'b0, m60, l60});
        end
        ld60 = 1'b1; ldm60 = 3'd1; ldl60 = 4'd10;
        step();
        ld60 = 1'b0;
        checks++;
        if ({e60, 1'b0, m60, l60} !== {1'b1, 8'h46}) begin
            errors++; $display("FAIL load_lsd10 got=%b/%h exp=1/46", e60, {1'b0, m60, l60});
        end
        // Load while the counter sits at 59 with a tick: load wins, no carry
        ld60 = 1'b1; ldm60 = 3'd5; ldl60 = 4'd9;
        step();
        ld60 = 1'b1; en60 = 1'b1; ldm60 = 3'd1; ldl60 = 4'd2;
        step();
        ld60 = 1'b0; en60 = 1'b0;
        checks++;
        if ({c60, e60, 1'b0, m60, l60} !== {2'b00, 8'h12}) begin
            errors++; $display("FAIL load_wrap got=%b%b/%h exp=00/12", c60, e60, {1'b0, m60, l60});
        end
        ld60 = 1'b1; ldm60 = 3'd6; ldl60 = 4'd0;
        step();
        ld60 = 1'b0;
        checks++;
        if ({e60, 1'b0, m60, l60} !== {1'b1, 8'h12}) begin
            errors++; $display("FAIL load_60 got=%b/%h exp=1/12", e60, {1'b0, m60, l60});
        end
    endtask

    task automatic test_reset_mid();
        ld60 = 1'b1; ldm60 = 3'd5; ldl60 = 4'd9;
        step();
        ld60 = 1'b0;
        en60 = 1'b1; rst_n = 1'b0;
        step();
        en60 = 1'b0; rst_n = 1'b1;
        checks++;
        if ({c60, 1'b0, m60, l60} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL reset_mid got=%b/%h exp=0/00", c60, {1'b0, m60, l60});
        end
        checks++;
        if ({2'b0, m24, l24} !== 8'h07) begin
            errors++; $display("FAIL reset_mid_u24 got=%h exp=07", {2'b0, m24, l24});
        end
    endtask

`ifdef MAQ_BCD_DOWN_EN
    task automatic test_count_down();
        dir60 = 1'b1;
        ld60 = 1'b1; ldm60 = 3'd1; ldl60 = 4'd0;
        step();
        ld60 = 1'b0; en60 = 1'b1;
        step();
        en60 = 1'b0;
        checks++;
        if ({b60, 1'b0, m60, l60} !== {1'b0, 8'h09}) begin
            errors++; $display("FAIL down_10 got=%b/%h exp=0/09", b60, {1'b0, m60, l60});
        end
        ld60 = 1'b1; ldm60 = 3'd0; ldl60 = 4'd0;
        step();
        ld60 = 1'b0; en60 = 1'b1;
        step();
        en60 = 1'b0;
        checks++;
        if ({b60, c60, 1'b0, m60, l60} !== {2'b10, 8'h59}) begin
            errors++; $display("FAIL down_wrap got=%b%b/%h exp=10/59", b60, c60, {1'b0, m60, l60});
        end
        step();
        checks++;
        if (b60 !== 1'b0) begin
            errors++; $display("FAIL down_borrow_clear got=%b exp=0", b60);
        end
        dir60 = 1'b0;
    endtask
`endif

    task automatic test_chain();
        ld_c = 1'b1;
        step();
        ld_c = 1'b0;
        checks++;
        if ({2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l} !== 24'h235959) begin
            errors++; $display("FAIL chain_load got=%h exp=235959", {2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l});
        end
        en_c = 1'b1;
        step();
        en_c = 1'b0;
        checks++;
        if ({s_c, mi_c, h_c, 2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l} !== {3'b100, 24'h235900}) begin
            errors++; $display("FAIL chain_sec got=%b%b%b/%h exp=100/235900", s_c, mi_c, h_c, {2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l});
        end
        step();
        checks++;
        if ({s_c, mi_c, h_c, 2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l} !== {3'b010, 24'h230000}) begin
            errors++; $display("FAIL chain_min got=%b%b%b/%h exp=010/230000", s_c, mi_c, h_c, {2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l});
        end
        step();
        checks++;
        if ({s_c, mi_c, h_c, 2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l} !== {3'b001, 24'h000000}) begin
            errors++; $display("FAIL chain_hr got=%b%b%b/%h exp=001/000000", s_c, mi_c, h_c, {2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l});
        end
        step();
        checks++;
        if ({s_c, mi_c, h_c, 2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l} !== {3'b000, 24'h000000}) begin
            errors++; $display("FAIL chain_settle got=%b%b%b/%h exp=000/000000", s_c, mi_c, h_c, {2'b0, h_m, h_l, 1'b0, mi_m, mi_l, 1'b0, s_m, s_l});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en60 = 1'b0; ld60 = 1'b0; ldl60 = 4'd0; ldm60 = 3'd0;
        en24 = 1'b0; ld24 = 1'b0; ldl24 = 4'd0; ldm24 = 2'd0;
        en_c = 1'b0; ld_c = 1'b0;
`ifdef MAQ_BCD_DOWN_EN
        dir60 = 1'b0;
`endif
        #1;
        test_reset();
        test_count_up();
        test_mod24();
        test_load_priority();
        test_reset_mid();
`ifdef MAQ_BCD_DOWN_EN
        test_count_down();
`endif
        test_chain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
